// File: rtl/addr_rf_stream.sv
// Expands a compressed group table (row offset, channel, cumulative end pointer per group)
// into a valid/ready stream of (row, col, ch, idx) entries with out-of-bounds flagging.
module addr_rf_stream #(
  parameter int NG    = 4,
  parameter int LEN_W = 11,
  parameter int HW    = 7,
  parameter int RW    = 3,
  parameter int KW    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [HW-1:0]       i_h,
  input  logic [HW-1:0]       i_w,
  input  logic [RW-1:0]       i_s,
  input  logic [NG*RW-1:0]    i_r,
  input  logic [NG*KW-1:0]    i_k,
  input  logic [NG*LEN_W-1:0] i_ptr,
  input  logic [LEN_W-1:0]    i_length,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [HW-1:0]       o_row,
  output logic [HW-1:0]       o_col,
  output logic [KW-1:0]       o_ch,
  output logic [LEN_W-1:0]    o_idx,
  output logic                o_oob,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_finish,
  output logic                o_err
);

  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         h_q, h_d, w_q, w_d;
  logic [RW-1:0]         s_q, s_d;
  logic [NG*RW-1:0]      r_q, r_d;
  logic [NG*KW-1:0]      k_q, k_d;
  logic [NG*LEN_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]      len_q, len_d, n_q, n_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic [HW-1:0]         row_q, row_d, col_q, col_d;
  logic [KW-1:0]         ch_q, ch_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic                  oob_q, oob_d, last_q, last_d;

  logic                  load;
  logic [GW-1:0]         grp;
  logic [RW-1:0]         r_sel;
  logic [HW:0]           row_diff, col_diff;

  // Table is usable when pointers never decrease and cover the requested length.
  function automatic logic table_ok(input logic [NG*LEN_W-1:0] ptr, input logic [LEN_W-1:0] len);
    logic ok;
    ok = (len <= ptr[(NG-1)*LEN_W +: LEN_W]);
    for (int g = 1; g < NG; g++) begin
      if (ptr[g*LEN_W +: LEN_W] < ptr[(g-1)*LEN_W +: LEN_W]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Lowest group whose exclusive end lies beyond n; empty groups fall through naturally.
  function automatic logic [GW-1:0] find_group(input logic [LEN_W-1:0] n,
                                               input logic [NG*LEN_W-1:0] ptr);
    logic [GW-1:0] sel;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (!found && (n < ptr[g*LEN_W +: LEN_W])) begin
        sel   = GW'(g);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign grp      = find_group(n_q, ptr_q);
  assign r_sel    = r_q[grp*RW +: RW];
  // The extra top bit of each difference is the borrow that marks a wrapped coordinate.
  assign row_diff = {1'b0, h_q} - {{(HW+1-RW){1'b0}}, r_sel};
  assign col_diff = {1'b0, w_q} - {{(HW+1-RW){1'b0}}, s_q};

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    w_d     = w_q;
    s_d     = s_q;
    r_d     = r_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    n_d     = n_q;
    err_d   = err_q;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    oob_d   = oob_q;
    last_d  = last_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          h_d     = i_h;
          w_d     = i_w;
          s_d     = i_s;
          r_d     = i_r;
          k_d     = i_k;
          ptr_d   = i_ptr;
          len_d   = i_length;
          n_d     = '0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!table_ok(ptr_q, len_q)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (len_q == '0) begin
          state_d = S_DONE;
        end else begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (valid_q && i_ready && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end else if ((!valid_q || i_ready) && (n_q < len_q)) begin
          load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
      row_d   = row_diff[HW-1:0];
      col_d   = col_diff[HW-1:0];
      ch_d    = k_q[grp*KW +: KW];
      idx_d   = n_q;
      oob_d   = row_diff[HW] | col_diff[HW];
      last_d  = (n_q == len_q - 1'b1);
      n_d     = n_q + 1'b1;
    end

    // Abort overrides everything, including a beat handshaking this same cycle.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      w_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      idx_q   <= '0;
      oob_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      w_q     <= w_d;
      s_q     <= s_d;
      r_q     <= r_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      n_q     <= n_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      oob_q   <= oob_d;
      last_q  <= last_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_row    = row_q;
  assign o_col    = col_q;
  assign o_ch     = ch_q;
  assign o_idx    = idx_q;
  assign o_oob    = oob_q;
  assign o_last   = last_q;
  assign o_busy   = (state_q != S_IDLE);
  assign o_finish = (state_q == S_DONE);
  assign o_err    = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_addr_rf_stream.sv
// Randomized and directed bench for addr_rf_stream against a list-based expansion model.
module tb_addr_rf_stream;

  localparam int NG = 4, LEN_W = 11, HW = 7, RW = 3, KW = 5;
  localparam int MASK = (1 << HW) - 1;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
  logic [HW-1:0]       i_h = '0, i_w = '0;
  logic [RW-1:0]       i_s = '0;
  logic [NG*RW-1:0]    i_r = '0;
  logic [NG*KW-1:0]    i_k = '0;
  logic [NG*LEN_W-1:0] i_ptr = '0;
  logic [LEN_W-1:0]    i_length = '0;
  logic                o_valid, o_oob, o_last, o_busy, o_finish, o_err;
  logic [HW-1:0]       o_row, o_col;
  logic [KW-1:0]       o_ch;
  logic [LEN_W-1:0]    o_idx;

  addr_rf_stream #(.NG(NG), .LEN_W(LEN_W), .HW(HW), .RW(RW), .KW(KW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_h(i_h), .i_w(i_w), .i_s(i_s), .i_r(i_r), .i_k(i_k), .i_ptr(i_ptr),
    .i_length(i_length), .o_valid(o_valid), .i_ready(i_ready), .o_row(o_row),
    .o_col(o_col), .o_ch(o_ch), .o_idx(o_idx), .o_oob(o_oob), .o_last(o_last),
    .o_busy(o_busy), .o_finish(o_finish), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int row; int col; int ch; int idx; int oob; int last;
  } beat_t;

  int n_checks = 0;
  int n_errors = 0;
  int ptr[NG], r[NG], k[NG];
  int h, w, s, len;
  int obs_row, obs_col, obs_oob;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_table();
    i_h = HW'(h);
    i_w = HW'(w);
    i_s = RW'(s);
    i_length = LEN_W'(len);
    for (int g = 0; g < NG; g++) begin
      i_r[g*RW +: RW]       = RW'(r[g]);
      i_k[g*KW +: KW]       = KW'(k[g]);
      i_ptr[g*LEN_W +: LEN_W] = LEN_W'(ptr[g]);
    end
  endtask

  task automatic scramble_inputs();
    i_h = HW'($urandom);
    i_w = HW'($urandom);
    i_s = RW'($urandom);
    i_r = NG*RW'($urandom);
    i_k = NG*KW'($urandom);
    i_ptr = {$urandom, $urandom};
    i_length = LEN_W'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_finish"}, int'(o_finish), 0);
    chk({tag, "_err"}, int'(o_err), 0);
    chk({tag, "_payload"}, int'(o_row) + int'(o_col) + int'(o_ch) + int'(o_idx), 0);
    chk({tag, "_flags"}, int'(o_oob) + int'(o_last), 0);
  endtask

  // rmode: 0 ready always high, 1 ready toggling, 2 random ready. abort_idx < 0 means no abort.
  task automatic run_txn(input int rmode, input int abort_idx);
    beat_t q[$];
    beat_t b, prev;
    int    exp_err, nxt, g;
    bit    done, stall, rdy, ph, aborted;
    exp_err = (len > ptr[NG-1]) ? 1 : 0;
    for (int i = 1; i < NG; i++) if (ptr[i] < ptr[i-1]) exp_err = 1;
    if (exp_err == 0) begin
      for (int n = 0; n < len; n++) begin
        g = 0;
        while (n >= ptr[g]) g++;
        b.row  = (h - r[g]) & MASK;
        b.col  = (w - s) & MASK;
        b.ch   = k[g];
        b.idx  = n;
        b.oob  = ((r[g] > h) || (s > w)) ? 1 : 0;
        b.last = (n == len - 1) ? 1 : 0;
        q.push_back(b);
      end
    end
    @(negedge i_clk);
    drive_table();
    i_start = 1'b1;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_in_check", int'(o_busy), 1);
    chk("valid_in_check", int'(o_valid), 0);
    nxt = 0; done = 0; stall = 0; ph = 0; aborted = 0;
    prev = '{default: 0};
    for (int cyc = 2; cyc < 400 && !done; cyc++) begin
      @(negedge i_clk);
      scramble_inputs();
      i_start = 1'($urandom);
      if (cyc == 2 && q.size() > 0) chk("first_valid_latency", int'(o_valid), 1);
      if (o_finish) begin
        chk("beats_delivered", nxt, q.size());
        chk("finish_err", int'(o_err), exp_err);
        chk("valid_at_finish", int'(o_valid), 0);
        done = 1;
        i_start = 1'b0;
        i_ready = 1'b0;
      end else if (o_valid) begin
        if (nxt >= q.size()) begin
          chk("extra_beat", int'(o_valid), 0);
          done = 1;
          i_start = 1'b0;
        end else begin
          chk("row", int'(o_row), q[nxt].row);
          chk("col", int'(o_col), q[nxt].col);
          chk("ch", int'(o_ch), q[nxt].ch);
          chk("idx", int'(o_idx), q[nxt].idx);
          chk("oob", int'(o_oob), q[nxt].oob);
          chk("last", int'(o_last), q[nxt].last);
          if (stall) chk("stall_stable", int'(o_row) ^ int'(o_ch) << 8 ^ int'(o_idx) << 16,
                         prev.row ^ prev.ch << 8 ^ prev.idx << 16);
          obs_row = int'(o_row);
          obs_col = int'(o_col);
          obs_oob = int'(o_oob);
          prev = q[nxt];
          if (abort_idx >= 0 && nxt == abort_idx) begin
            i_abort = 1'b1;
            i_ready = 1'b1;
            i_start = 1'b0;
            @(negedge i_clk);
            i_abort = 1'b0;
            chk("abort_valid", int'(o_valid), 0);
            chk("abort_busy", int'(o_busy), 0);
            chk("abort_finish", int'(o_finish), 0);
            repeat (3) begin
              @(negedge i_clk);
              chk("post_abort_finish", int'(o_finish), 0);
            end
            aborted = 1;
            done = 1;
          end else begin
            case (rmode)
              0:       rdy = 1'b1;
              1:       rdy = ph;
              default: rdy = 1'($urandom);
            endcase
            i_ready = rdy;
            stall = !rdy;
            if (rdy) nxt++;
          end
        end
      end else begin
        chk("no_bubble", int'(o_valid), (q.size() == 0) ? 0 : 1);
        i_ready = 1'($urandom);
      end
      ph = !ph;
    end
    if (!done) chk("finish_timeout", int'(o_finish), 1);
    if (done && !aborted) begin
      @(negedge i_clk);
      chk("finish_one_cycle", int'(o_finish), 0);
      chk("idle_after_finish", int'(o_busy), 0);
    end
  endtask

  task automatic set_example();
    ptr = '{2, 5, 5, 8};
    r   = '{1, 2, 3, 0};
    k   = '{4, 5, 6, 7};
    h = 10; w = 9; s = 2; len = 8;
  endtask

  initial begin
    #12;
    check_outputs_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    set_example();
    run_txn(0, -1);
    run_txn(1, -1);
    set_example();
    ptr = '{3, 2, 6, 8};
    run_txn(2, -1);
    set_example();
    len = 9;
    run_txn(0, -1);
    set_example();
    len = 0;
    run_txn(0, -1);

    ptr = '{1, 1, 1, 1};
    r   = '{3, 0, 0, 0};
    k   = '{1, 2, 3, 4};
    h = 1; w = 0; s = 1; len = 1;
    run_txn(0, -1);
    chk("oob_row_wrap", obs_row, 126);
    chk("oob_col_wrap", obs_col, 127);
    chk("oob_flag", obs_oob, 1);

    set_example();
    run_txn(0, 3);
    run_txn(2, -1);

    // start and abort together in IDLE must leave the block idle
    @(negedge i_clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("start_abort_idle", int'(o_busy), 0);

    for (int t = 0; t < 30; t++) begin
      int p;
      p = 0;
      for (int g = 0; g < NG; g++) begin
        p += $urandom_range(0, 4);
        ptr[g] = p;
        r[g] = $urandom_range(0, 7);
        k[g] = $urandom_range(0, 31);
      end
      if ($urandom_range(0, 5) == 0) ptr[$urandom_range(0, NG-1)] = $urandom_range(0, 12);
      h = $urandom_range(0, MASK);
      w = $urandom_range(0, 9);
      s = $urandom_range(0, 7);
      len = $urandom_range(0, ptr[NG-1] + 1);
      run_txn(2, ($urandom_range(0, 7) == 0) ? 0 : -1);
    end

    // asynchronous reset in the middle of a run
    set_example();
    @(negedge i_clk);
    drive_table();
    i_start = 1'b1;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("pre_reset_valid", int'(o_valid), 1);
    #2 i_rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b0;
    @(negedge i_clk);
    chk("after_reset_idle", int'(o_busy), 0);
    run_txn(0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
